// File: rtl/pwm_seq_ctrl.sv
// ============================================================================
//  Module      : pwm_seq_ctrl
//  Description : Steps a timer through a table of compare-value pairs. Each
//                entry is held for a programmable number of timer periods.
//                Once the final entry completes, the sequence either finishes
//                or wraps back to entry 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_seq_ctrl #(
    parameter int AW    = 3,
    parameter int RPT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [AW-1:0]    last_idx,
    input  logic [RPT_W-1:0] rpt,
    input  logic             wr,
    input  logic [AW-1:0]    wr_addr,
    input  logic [31:0]      wr_cmpx,
    input  logic [31:0]      wr_cmpy,
    input  logic             timeout_flag,
    output logic             tmr_en,
    output logic [31:0]      cmpx,
    output logic [31:0]      cmpy,
    output logic             busy,
    output logic [AW-1:0]    idx,
    output logic             done,
    output logic             entry_pulse
);

    localparam int             C_DEPTH   = 2**AW;
    localparam logic [RPT_W-1:0] C_RPT_ONE = RPT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [31:0]      cmpx_q, cmpx_d;
    logic [31:0]      cmpy_q, cmpy_d;
    logic             done_q, done_d;
    logic             entry_q, entry_d;
    logic             timeout_q;

    // Compare table; contents deliberately survive reset.
    logic [31:0]      tbl_x_q [C_DEPTH];
    logic [31:0]      tbl_y_q [C_DEPTH];

    logic             w_event;
    logic             w_last;
    logic [AW-1:0]    w_adv_idx;
    logic [RPT_W-1:0] w_rpt_eff;

    // A repeat count of zero means one period.
    assign w_rpt_eff = (rpt == '0) ? C_RPT_ONE : rpt;

    // Rising edge of the timer's level flag; only meaningful while running.
    assign w_event   = timeout_flag & ~timeout_q & (state_q == S_RUN);

    assign w_last    = (idx_q == last_idx);

    // After the last entry the only way onward is a loop back to 0; otherwise
    // step forward, wrapping naturally at 2**AW.
    assign w_adv_idx = w_last ? '0 : (idx_q + 1'b1);

    // Table write port; reads below see the pre-write contents on a
    // same-cycle write because the array only updates at the clock edge.
    always_ff @(posedge clk) begin
        if (wr) begin
            tbl_x_q[wr_addr] <= wr_cmpx;
            tbl_y_q[wr_addr] <= wr_cmpy;
        end
    end

    // Delayed copy of the timeout flag, tracked in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_flag;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rpt_cnt_q <= '0;
            cmpx_q    <= '0;
            cmpy_q    <= '0;
            done_q    <= 1'b0;
            entry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rpt_cnt_q <= rpt_cnt_d;
            cmpx_q    <= cmpx_d;
            cmpy_q    <= cmpy_d;
            done_q    <= done_d;
            entry_q   <= entry_d;
        end
    end

    // Next-state logic: start/load/advance/finish, with stop overriding all.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rpt_cnt_d = rpt_cnt_q;
        cmpx_d    = cmpx_q;
        cmpy_d    = cmpy_q;
        done_d    = 1'b0;
        entry_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cmpx_d    = tbl_x_q[idx_q];
                cmpy_d    = tbl_y_q[idx_q];
                rpt_cnt_d = w_rpt_eff;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (w_event) begin
                    if (rpt_cnt_q > C_RPT_ONE) begin
                        rpt_cnt_d = rpt_cnt_q - C_RPT_ONE;
                    end else if (!w_last || loop) begin
                        idx_d     = w_adv_idx;
                        cmpx_d    = tbl_x_q[w_adv_idx];
                        cmpy_d    = tbl_y_q[w_adv_idx];
                        rpt_cnt_d = w_rpt_eff;
                        entry_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: return to idle and freeze everything else, no done pulse.
        if (stop) begin
            state_d   = S_IDLE;
            idx_d     = idx_q;
            rpt_cnt_d = rpt_cnt_q;
            cmpx_d    = cmpx_q;
            cmpy_d    = cmpy_q;
            done_d    = 1'b0;
            entry_d   = 1'b0;
        end
    end

    // Decoded from the state register so reset clears them asynchronously.
    assign tmr_en      = (state_q == S_RUN);
    assign busy        = (state_q != S_IDLE);
    assign idx         = idx_q;
    assign cmpx        = cmpx_q;
    assign cmpy        = cmpy_q;
    assign done        = done_q;
    assign entry_pulse = entry_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_seq_ctrl.sv
// ============================================================================
//  Module      : tb_pwm_seq_ctrl
//  Description : Self-checking bench for pwm_seq_ctrl: directed vector table,
//                hand sequences for corner cases, and a randomized run
//                against a behavioural sequencer model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [2:0]  last_idx = '0;
    logic [7:0]  rpt = 8'd1;
    logic        wr = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_cmpx = '0, wr_cmpy = '0;
    logic        timeout_flag = 1'b0;
    logic        tmr_en, busy, done, entry_pulse;
    logic [31:0] cmpx, cmpy;
    logic [2:0]  idx;

    int n_chk = 0;
    int n_err = 0;

    pwm_seq_ctrl #(.AW(3), .RPT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .last_idx(last_idx), .rpt(rpt), .wr(wr), .wr_addr(wr_addr),
        .wr_cmpx(wr_cmpx), .wr_cmpy(wr_cmpy), .timeout_flag(timeout_flag),
        .tmr_en(tmr_en), .cmpx(cmpx), .cmpy(cmpy), .busy(busy), .idx(idx),
        .done(done), .entry_pulse(entry_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Sequencer described as "running / about to load / periods left".
    bit          m_run, m_load, m_done, m_entry, m_tq;
    int          m_idx, m_left;
    logic [31:0] m_cx, m_cy;
    logic [31:0] m_tx [8];
    logic [31:0] m_ty [8];

    task automatic model_reset();
        m_run = 0; m_load = 0; m_done = 0; m_entry = 0; m_tq = 0;
        m_idx = 0; m_left = 0; m_cx = 0; m_cy = 0;
    endtask

    task automatic model_step();
        bit rise;
        int per;
        if (!rst_n) begin
            model_reset();
        end else begin
            rise    = timeout_flag && !m_tq && m_run;
            per     = (rpt == 0) ? 1 : int'(rpt);
            m_done  = 0;
            m_entry = 0;
            if (stop) begin
                m_run = 0; m_load = 0;
            end else if (m_load) begin
                m_cx = m_tx[m_idx]; m_cy = m_ty[m_idx];
                m_left = per; m_load = 0; m_run = 1;
            end else if (m_run) begin
                if (rise) begin
                    if (m_left > 1) begin
                        m_left--;
                    end else if (m_idx != int'(last_idx) || loop) begin
                        m_idx   = (m_idx == int'(last_idx)) ? 0 : (m_idx + 1) % 8;
                        m_cx    = m_tx[m_idx]; m_cy = m_ty[m_idx];
                        m_left  = per;
                        m_entry = 1;
                    end else begin
                        m_run = 0; m_done = 1;
                    end
                end
            end else if (start) begin
                m_idx = 0; m_load = 1;
            end
            m_tq = timeout_flag;
        end
        if (wr) begin
            m_tx[wr_addr] = wr_cmpx;
            m_ty[wr_addr] = wr_cmpy;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("busy",        32'(busy),        32'(m_run | m_load));
        chk("tmr_en",      32'(tmr_en),      32'(m_run));
        chk("idx",         32'(idx),         32'(m_idx));
        chk("cmpx",        cmpx,             m_cx);
        chk("cmpy",        cmpy,             m_cy);
        chk("done",        32'(done),        32'(m_done));
        chk("entry_pulse", 32'(entry_pulse), 32'(m_entry));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic pulse_tf();
        timeout_flag = 1'b1; tick();
        timeout_flag = 1'b0; tick();
    endtask

    task automatic abort();
        stop = 1'b1; tick();
        stop = 1'b0; tick();
    endtask

    // ---------------- directed vectors (test 1) ----------------
    typedef struct {
        logic        start;
        logic        tf;
        logic        exp_tmr;
        logic [31:0] exp_cx;
        logic [31:0] exp_cy;
        logic [2:0]  exp_idx;
        logic        exp_done;
        logic        exp_entry;
    } vec_t;

    vec_t vt [8];

    initial begin
        model_reset();
        for (int i = 0; i < 8; i++) begin
            m_tx[i] = 0; m_ty[i] = 0;
        end

        //             start tf  tmr  cx  cy  idx done entry
        vt[0] = '{1'b1, 1'b0, 1'b0,  0,  0, 3'd0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 10, 20, 3'd0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 30, 40, 3'd1, 1'b0, 1'b1};
        vt[3] = '{1'b0, 1'b0, 1'b1, 30, 40, 3'd1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 50, 60, 3'd2, 1'b0, 1'b1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 50, 60, 3'd2, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 50, 60, 3'd2, 1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b0, 50, 60, 3'd2, 1'b0, 1'b0};

        // Reset state
        tick(); tick();
        chk("rst_busy",   32'(busy),   0);
        chk("rst_tmr_en", 32'(tmr_en), 0);
        chk("rst_cmpx",   cmpx,        0);
        rst_n = 1'b1;

        // Fill the whole table: 0..2 from the test plan, the rest filler
        wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 3'(i);
            wr_cmpx = (i < 3) ? 32'(10 + 20 * i) : 32'(100 + i);
            wr_cmpy = (i < 3) ? 32'(20 + 20 * i) : 32'(200 + i);
            tick();
        end
        wr = 1'b0;

        // Test 1: table-driven basic sequence
        last_idx = 3'd2; rpt = 8'd1; loop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            start = vt[k].start; timeout_flag = vt[k].tf;
            tick();
            chk($sformatf("t1_tmr[%0d]", k),   32'(tmr_en),      32'(vt[k].exp_tmr));
            chk($sformatf("t1_cmpx[%0d]", k),  cmpx,             vt[k].exp_cx);
            chk($sformatf("t1_cmpy[%0d]", k),  cmpy,             vt[k].exp_cy);
            chk($sformatf("t1_idx[%0d]", k),   32'(idx),         32'(vt[k].exp_idx));
            chk($sformatf("t1_done[%0d]", k),  32'(done),        32'(vt[k].exp_done));
            chk($sformatf("t1_entry[%0d]", k), 32'(entry_pulse), 32'(vt[k].exp_entry));
        end
        start = 1'b0; timeout_flag = 1'b0;

        // Test 2: rpt=3, long flag counts once
        rpt = 8'd3;
        start = 1'b1; tick(); start = 1'b0; tick();
        timeout_flag = 1'b1;
        repeat (5) tick();
        timeout_flag = 1'b0; tick();
        chk("t2_idx_after_hold", 32'(idx), 0);
        pulse_tf();
        chk("t2_idx_after_2", 32'(idx), 0);
        timeout_flag = 1'b1; tick();
        chk("t2_idx_after_3", 32'(idx), 1);
        chk("t2_entry", 32'(entry_pulse), 1);
        chk("t2_cmpx", cmpx, 30);
        timeout_flag = 1'b0; tick();
        abort();

        // Test 3: loop over entries 0..1
        rpt = 8'd1; loop = 1'b1; last_idx = 3'd1;
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int k = 0; k < 4; k++) begin
            timeout_flag = 1'b1; tick();
            chk("t3_idx",   32'(idx),         32'((k + 1) % 2));
            chk("t3_entry", 32'(entry_pulse), 1);
            chk("t3_tmr",   32'(tmr_en),      1);
            timeout_flag = 1'b0; tick();
            chk("t3_tmr_hold", 32'(tmr_en), 1);
            chk("t3_no_done",  32'(done),   0);
        end
        abort();

        // Test 4: start ignored in RUN; stop beats final event
        loop = 1'b0; last_idx = 3'd1;
        start = 1'b1; tick(); start = 1'b0; tick();
        pulse_tf();
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_start_ign_idx",  32'(idx),  1);
        chk("t4_start_ign_cmpx", cmpx,      30);
        chk("t4_start_ign_busy", 32'(busy), 1);
        tick();
        timeout_flag = 1'b1; stop = 1'b1; tick();
        timeout_flag = 1'b0; stop = 1'b0;
        chk("t4_stop_busy", 32'(busy), 0);
        chk("t4_stop_done", 32'(done), 0);
        chk("t4_stop_cmpx", cmpx,      30);
        tick();
        chk("t4_stop_done2", 32'(done), 0);

        // Test 5: rpt=0 acts as 1; write to next entry during advance
        rpt = 8'd0; last_idx = 3'd2;
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("t5_cmpx0", cmpx, 10);
        timeout_flag = 1'b1; wr = 1'b1; wr_addr = 3'd1;
        wr_cmpx = 32'd777; wr_cmpy = 32'd888; tick();
        wr = 1'b0; timeout_flag = 1'b0;
        chk("t5_old_cmpx", cmpx, 30);
        chk("t5_old_cmpy", cmpy, 40);
        chk("t5_idx",      32'(idx), 1);
        tick();
        pulse_tf();
        chk("t5_idx2", 32'(idx), 2);
        abort();

        // Test 6: async reset mid-RUN, table retained
        rpt = 8'd1;
        start = 1'b1; tick(); start = 1'b0; tick();
        pulse_tf();
        chk("t6_cmpx_new", cmpx, 777);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_tmr_async", 32'(tmr_en), 0);
        cmp_all();
        tick();
        rst_n = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("t6_reload_cmpx", cmpx, 10);
        chk("t6_reload_tmr",  32'(tmr_en), 1);
        abort();

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                rpt      = 8'($urandom_range(0, 3));
                last_idx = 3'($urandom_range(0, 7));
                loop     = 1'($urandom_range(0, 1));
            end
            start        = ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 59) == 0);
            timeout_flag = ($urandom_range(0, 2) == 0);
            wr           = ($urandom_range(0, 3) == 0);
            wr_addr      = 3'($urandom_range(0, 7));
            wr_cmpx      = $urandom;
            wr_cmpy      = $urandom;
            tick();
        end
        start = 1'b0; stop = 1'b0; wr = 1'b0; timeout_flag = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
